adquisicion_carga: RTL and testbench

ADQUISICION_CARGA -- requirements
Module: adquisicion_carga

---
 rtl/adquisicion_carga.sv | 139 +++++++++++++
 tb/tb_adquisicion_carga.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/adquisicion_carga.sv
// Two-channel battery charge acquisition: windowed averaging with sensor timeout detection.
// Optional build macro ADQ_HISTERESIS_EN adds output hysteresis on steady-state windows.
module adquisicion_carga #(
  parameter int VENTANA_LOG2   = 2,
  parameter int TIMEOUT_CICLOS = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] muestra_bateria1,
  input  logic [3:0] muestra_bateria2,
  input  logic       muestra_valida,
  output logic [3:0] carga_bateria1,
  output logic [3:0] carga_bateria2,
  output logic       carga_valida,
  output logic       listo,
  output logic       falla_sensor,
  output logic [1:0] estado_dbg
);

  // Handshake: there is no backpressure. A sample pair is accepted on every
  // rising edge where muestra_valida=1; carga_valida is a one-cycle pulse per window.

  localparam int AW = 4 + VENTANA_LOG2;
  localparam logic [VENTANA_LOG2-1:0] CNT_LAST = '1;
  localparam logic [VENTANA_LOG2-1:0] CNT_ONE  = 1;
  localparam logic [15:0] TIMEOUT = 16'(TIMEOUT_CICLOS);

  localparam logic [1:0] LLENANDO = 2'd0;
  localparam logic [1:0] ESTABLE  = 2'd1;
  localparam logic [1:0] FALLA    = 2'd2;

  logic [1:0]              state_q, state_d;
  logic [AW-1:0]           acc1_q, acc1_d, acc2_q, acc2_d;
  logic [VENTANA_LOG2-1:0] cnt_q, cnt_d;
  logic [15:0]             idle_q, idle_d;
  logic [3:0]              carga1_q, carga1_d, carga2_q, carga2_d;
  logic                    valida_q, valida_d;

  logic [AW-1:0] sum1, sum2, sh1, sh2;
  logic [3:0]    avg1, avg2;
  logic          fin_ventana;

`ifdef ADQ_HISTERESIS_EN
  // A steady output only moves for a step of 2 or more, or to either rail.
  function automatic logic cambia(input logic [3:0] nuevo, input logic [3:0] viejo);
    logic [3:0] diff;
    diff = (nuevo > viejo) ? (nuevo - viejo) : (viejo - nuevo);
    return (diff >= 4'd2) || (nuevo == 4'd0) || (nuevo == 4'd15);
  endfunction
`endif

  always_comb begin
    sum1 = acc1_q + {{VENTANA_LOG2{1'b0}}, muestra_bateria1};
    sum2 = acc2_q + {{VENTANA_LOG2{1'b0}}, muestra_bateria2};
    sh1  = sum1 >> VENTANA_LOG2;
    sh2  = sum2 >> VENTANA_LOG2;
    avg1 = sh1[3:0];
    avg2 = sh2[3:0];
    fin_ventana = muestra_valida && (cnt_q == CNT_LAST);

    state_d  = state_q;
    acc1_d   = acc1_q;
    acc2_d   = acc2_q;
    cnt_d    = cnt_q;
    idle_d   = idle_q;
    carga1_d = carga1_q;
    carga2_d = carga2_q;
    valida_d = 1'b0;

    if (muestra_valida) begin
      // An accepted sample always beats a timeout landing on the same edge.
      idle_d = '0;
      if (fin_ventana) begin
        acc1_d   = '0;
        acc2_d   = '0;
        cnt_d    = '0;
        valida_d = 1'b1;
        state_d  = ESTABLE;
`ifdef ADQ_HISTERESIS_EN
        if (state_q == ESTABLE) begin
          if (cambia(avg1, carga1_q)) carga1_d = avg1;
          if (cambia(avg2, carga2_q)) carga2_d = avg2;
        end else begin
          carga1_d = avg1;
          carga2_d = avg2;
        end
`else
        carga1_d = avg1;
        carga2_d = avg2;
`endif
      end else begin
        acc1_d = sum1;
        acc2_d = sum2;
        cnt_d  = cnt_q + CNT_ONE;
        if (state_q == FALLA) state_d = LLENANDO;
      end
    end else begin
      if (idle_q != TIMEOUT) idle_d = idle_q + 16'd1;
      if ((state_q != FALLA) && (idle_d == TIMEOUT)) begin
        state_d  = FALLA;
        acc1_d   = '0;
        acc2_d   = '0;
        cnt_d    = '0;
        carga1_d = '0;
        carga2_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= LLENANDO;
      acc1_q   <= '0;
      acc2_q   <= '0;
      cnt_q    <= '0;
      idle_q   <= '0;
      carga1_q <= '0;
      carga2_q <= '0;
      valida_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc1_q   <= acc1_d;
      acc2_q   <= acc2_d;
      cnt_q    <= cnt_d;
      idle_q   <= idle_d;
      carga1_q <= carga1_d;
      carga2_q <= carga2_d;
      valida_q <= valida_d;
    end
  end

  assign carga_bateria1 = carga1_q;
  assign carga_bateria2 = carga2_q;
  assign carga_valida   = valida_q;
  assign listo          = (state_q == ESTABLE);
  assign falla_sensor   = (state_q == FALLA);
  assign estado_dbg     = state_q;

endmodule

// File: tb/tb_adquisicion_carga.sv
// Bench for adquisicion_carga: directed scenarios plus random traffic, checked against a
// window-list reference model through per-cycle and per-window expected queues.
module tb_adquisicion_carga;

  localparam int VL = 2;
  localparam int T  = 16;
  localparam int N  = 1 << VL;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] muestra_bateria1, muestra_bateria2;
  logic       muestra_valida;
  logic [3:0] carga_bateria1, carga_bateria2;
  logic       carga_valida, listo, falla_sensor;
  logic [1:0] estado_dbg;

  adquisicion_carga #(.VENTANA_LOG2(VL), .TIMEOUT_CICLOS(T)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .muestra_bateria1(muestra_bateria1),
    .muestra_bateria2(muestra_bateria2),
    .muestra_valida(muestra_valida),
    .carga_bateria1(carga_bateria1),
    .carga_bateria2(carga_bateria2),
    .carga_valida(carga_valida),
    .listo(listo),
    .falla_sensor(falla_sensor),
    .estado_dbg(estado_dbg)
  );

  always #5 clk = ~clk;

  // Scoreboard: per-cycle status {c1,c2,valida,listo,falla} and per-window results {c1,c2}.
  logic [10:0] exp_q[$];
  logic [7:0]  win_q[$];
  int n_vec = 0;
  int n_bad = 0;

  // Reference model state.
  logic [3:0] m_c1, m_c2;
  bit         m_listo, m_falla;
  int         m_idle;
  int         w1[$], w2[$];

`ifdef ADQ_HISTERESIS_EN
  function automatic bit cambia(input int nuevo, input int viejo);
    int d;
    d = nuevo - viejo;
    if (d < 0) d = -d;
    return (d >= 2) || (nuevo == 0) || (nuevo == 15);
  endfunction
`endif

  task automatic model_step(input logic r, input logic v, input logic [3:0] a, input logic [3:0] b);
    bit valid_e;
    int s1, s2, a1, a2;
    valid_e = 0;
    if (!r) begin
      m_c1 = 0; m_c2 = 0; m_listo = 0; m_falla = 0; m_idle = 0;
      w1.delete(); w2.delete();
    end else if (v) begin
      m_idle = 0;
      m_falla = 0;
      w1.push_back(int'(a));
      w2.push_back(int'(b));
      if (w1.size() == N) begin
        s1 = 0; s2 = 0;
        foreach (w1[i]) s1 += w1[i];
        foreach (w2[i]) s2 += w2[i];
        a1 = s1 / N;
        a2 = s2 / N;
`ifdef ADQ_HISTERESIS_EN
        if (m_listo) begin
          if (cambia(a1, int'(m_c1))) m_c1 = 4'(a1);
          if (cambia(a2, int'(m_c2))) m_c2 = 4'(a2);
        end else begin
          m_c1 = 4'(a1);
          m_c2 = 4'(a2);
        end
`else
        m_c1 = 4'(a1);
        m_c2 = 4'(a2);
`endif
        valid_e = 1;
        m_listo = 1;
        w1.delete(); w2.delete();
        win_q.push_back({m_c1, m_c2});
      end
    end else begin
      m_idle++;
      if (!m_falla && m_idle >= T) begin
        m_falla = 1; m_listo = 0; m_c1 = 0; m_c2 = 0;
        w1.delete(); w2.delete();
      end
    end
    exp_q.push_back({m_c1, m_c2, valid_e, m_listo, m_falla});
  endtask

  // Driver tasks: inputs change on the falling edge, model predicts the next rising edge.
  task automatic drive(input logic r, input logic v, input logic [3:0] a, input logic [3:0] b);
    @(negedge clk);
    rst_n = r;
    muestra_valida = v;
    muestra_bateria1 = a;
    muestra_bateria2 = b;
    model_step(r, v, a, b);
  endtask

  task automatic sample(input logic [3:0] a, input logic [3:0] b);
    drive(1'b1, 1'b1, a, b);
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++)
      drive(1'b1, 1'b0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
  endtask

  task automatic window_const(input logic [3:0] a, input logic [3:0] b);
    for (int i = 0; i < N; i++) sample(a, b);
  endtask

  // Monitor: checks one cycle of status after every rising edge, and every window pulse.
  always @(posedge clk) begin
    logic [10:0] e;
    logic [7:0]  w;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_vec++;
      if ({carga_bateria1, carga_bateria2, carga_valida, listo, falla_sensor} !== e) begin
        n_bad++;
        $display("FAIL estado t=%0t: got c1=%0d c2=%0d valida=%b listo=%b falla=%b (st=%0d), expected c1=%0d c2=%0d valida=%b listo=%b falla=%b",
                 $time, carga_bateria1, carga_bateria2, carga_valida, listo, falla_sensor, estado_dbg,
                 e[10:7], e[6:3], e[2], e[1], e[0]);
      end
      if (carga_valida === 1'b1) begin
        n_vec++;
        if (win_q.size() == 0) begin
          n_bad++;
          $display("FAIL ventana t=%0t: unexpected carga_valida pulse, c1=%0d c2=%0d, no window expected",
                   $time, carga_bateria1, carga_bateria2);
        end else begin
          w = win_q.pop_front();
          if ({carga_bateria1, carga_bateria2} !== w) begin
            n_bad++;
            $display("FAIL ventana t=%0t: got c1=%0d c2=%0d, expected c1=%0d c2=%0d",
                     $time, carga_bateria1, carga_bateria2, w[7:4], w[3:0]);
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    muestra_valida = 1'b0;
    muestra_bateria1 = '0;
    muestra_bateria2 = '0;

    drive(1'b0, 1'b0, 4'd0, 4'd0);
    drive(1'b0, 1'b1, 4'd15, 4'd15);

    // Basic window: 8/0.
    window_const(4'd8, 4'd0);

    // Truncation with gaps between samples.
    sample(4'd15, 4'd5); gap(3);
    sample(4'd15, 4'd6); gap(3);
    sample(4'd14, 4'd5); gap(3);
    sample(4'd14, 4'd6);

    // Hysteresis sequence: 8, then 9, then 10.
    window_const(4'd8, 4'd3);
    window_const(4'd9, 4'd3);
    window_const(4'd10, 4'd3);

    // Timeout into fault, then recovery from fault.
    gap(T);
    gap(3);
    window_const(4'd12, 4'd7);

    // One cycle short of timeout, then a sample: no fault.
    gap(T - 1);
    sample(4'd2, 4'd9);
    gap(T - 1);
    sample(4'd3, 4'd9);
    sample(4'd4, 4'd9);
    sample(4'd5, 4'd9);

    // Reset mid-window discards the partial accumulation.
    sample(4'd15, 4'd15);
    sample(4'd15, 4'd15);
    drive(1'b0, 1'b1, 4'd15, 4'd15);
    window_const(4'd4, 4'd4);

    // Timeout before the first window ever completes.
    sample(4'd6, 4'd6);
    gap(T);
    sample(4'd1, 4'd1);
    gap(2);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 59) == 0) gap($urandom_range(10, T + 4));
      else if ($urandom_range(0, 249) == 0) drive(1'b0, 1'($urandom_range(0, 1)), 4'd0, 4'd0);
      else drive(1'b1, 1'($urandom_range(0, 3) != 0),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end

    drive(1'b1, 1'b0, 4'd0, 4'd0);
    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0 || win_q.size() != 0) begin
      n_bad++;
      $display("FAIL drenado: %0d status and %0d window entries left, expected 0 and 0",
               exp_q.size(), win_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
